// File: rtl/game_pkg.sv
// Shared types and widths for the game round timer and its displays.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

endpackage

// File: rtl/bcd_to_hex7.sv
// BCD digit to active-low seven-segment pattern (gfedcba); non-BCD codes blank the digit.
module bcd_to_hex7
  import game_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/game_timer.sv
// Two-digit BCD round countdown driven by the 1 s tick, with pause, restart and a time-up pulse.
module game_timer
  import game_pkg::*;
#(
  parameter int START_TENS = 6,
  parameter int START_ONES = 0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  output logic             slow_enable,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic [SEG_W-1:0] HEX1,
  output logic [SEG_W-1:0] HEX0,
  output logic             running,
  output logic             expired,
  output logic             time_up
);

  localparam logic [BCD_W-1:0] START_T = BCD_W'(START_TENS);
  localparam logic [BCD_W-1:0] START_O = BCD_W'(START_ONES);
  localparam bit START_ZERO = (START_TENS == 0) && (START_ONES == 0);

  state_t           state_reg;
  logic [BCD_W-1:0] tens_reg;
  logic [BCD_W-1:0] ones_reg;
  logic             tick_q_reg;
  logic             time_up_reg;
  logic             tick_rise;

  assign tick_rise = tick & ~tick_q_reg;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_reg   <= IDLE;
      tens_reg    <= START_T;
      ones_reg    <= START_O;
      tick_q_reg  <= 1'b1;
      time_up_reg <= 1'b0;
    end else begin
      tick_q_reg  <= tick;
      time_up_reg <= 1'b0;
      if (start) begin
        tens_reg <= START_T;
        ones_reg <= START_O;
        // A 00 start value has nothing to count: expire at once, pulsing only on entry.
        if (START_ZERO) begin
          state_reg   <= EXPIRED;
          time_up_reg <= (state_reg != EXPIRED);
        end else begin
          state_reg <= RUN;
        end
      end else begin
        case (state_reg)
          RUN: begin
            if (pause) begin
              state_reg <= PAUSE;
            end else if (tick_rise) begin
              if (ones_reg != 4'd0) begin
                ones_reg <= ones_reg - 4'd1;
                if (tens_reg == 4'd0 && ones_reg == 4'd1) begin
                  state_reg   <= EXPIRED;
                  time_up_reg <= 1'b1;
                end
              end else if (tens_reg != 4'd0) begin
                ones_reg <= 4'd9;
                tens_reg <= tens_reg - 4'd1;
              end
            end
          end
          PAUSE: begin
            if (!pause) state_reg <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign tens        = tens_reg;
  assign ones        = ones_reg;
  assign time_up     = time_up_reg;
  assign running     = (state_reg == RUN);
  assign expired     = (state_reg == EXPIRED);
  assign slow_enable = running;

  logic [BCD_W-1:0] digit [2];
  logic [SEG_W-1:0] seg   [2];

  assign digit[0] = ones_reg;
  assign digit[1] = tens_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      bcd_to_hex7 u_dec (
        .bcd (digit[gi]),
        .seg (seg[gi])
      );
    end
  endgenerate

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];

endmodule

// File: tb/tb_game_timer.sv
// Checks two timer instances (start 60 and start 02) against a seconds-count reference model.
module tb_game_timer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b1;
  logic       pause = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;

  logic       slow_a, slow_b, run_a, run_b, exp_a, exp_b, tu_a, tu_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;
  logic [6:0] hex1_a, hex0_a, hex1_b, hex0_b;

  always #10 CLOCK_50 = ~CLOCK_50;

  game_timer #(.START_TENS(6), .START_ONES(0)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .start(start_a), .pause(pause),
    .slow_enable(slow_a), .tens(tens_a), .ones(ones_a), .HEX1(hex1_a), .HEX0(hex0_a),
    .running(run_a), .expired(exp_a), .time_up(tu_a)
  );

  game_timer #(.START_TENS(0), .START_ONES(2)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .start(start_b), .pause(pause),
    .slow_enable(slow_b), .tens(tens_b), .ones(ones_b), .HEX1(hex1_b), .HEX0(hex0_b),
    .running(run_b), .expired(exp_b), .time_up(tu_b)
  );

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  int         checks = 0;
  int         errors = 0;
  int         m_sec [2];
  int         m_mode [2];
  bit         m_tu [2];
  bit         m_tq;
  int         start_sec [2] = '{60, 2};
  logic [6:0] hex_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h t=%0t", tag, inst, obs, exp, $time);
    end
  endtask

  // Reference behaviour in whole seconds: countdown, pause freeze, restart, expiry.
  task automatic model_edge(input int i, input bit r, input bit st, input bit p, input bit rise);
    m_tu[i] = 1'b0;
    if (!r) begin
      m_mode[i] = M_IDLE;
      m_sec[i]  = start_sec[i];
    end else if (st) begin
      m_sec[i] = start_sec[i];
      if (start_sec[i] == 0) begin
        m_tu[i]   = (m_mode[i] != M_EXP);
        m_mode[i] = M_EXP;
      end else begin
        m_mode[i] = M_RUN;
      end
    end else if (m_mode[i] == M_RUN) begin
      if (p) begin
        m_mode[i] = M_PAUSE;
      end else if (rise && m_sec[i] > 0) begin
        m_sec[i] = m_sec[i] - 1;
        if (m_sec[i] == 0) begin
          m_mode[i] = M_EXP;
          m_tu[i]   = 1'b1;
        end
      end
    end else if (m_mode[i] == M_PAUSE && !p) begin
      m_mode[i] = M_RUN;
    end
  endtask

  task automatic check_inst(input int i);
    int s;
    s = m_sec[i];
    chk("tens",    i, 8'(i == 0 ? tens_a : tens_b), 8'(s / 10));
    chk("ones",    i, 8'(i == 0 ? ones_a : ones_b), 8'(s % 10));
    chk("hex1",    i, 8'(i == 0 ? hex1_a : hex1_b), 8'(hex_tab[s / 10]));
    chk("hex0",    i, 8'(i == 0 ? hex0_a : hex0_b), 8'(hex_tab[s % 10]));
    chk("running", i, 8'(i == 0 ? run_a : run_b),   8'(m_mode[i] == M_RUN));
    chk("expired", i, 8'(i == 0 ? exp_a : exp_b),   8'(m_mode[i] == M_EXP));
    chk("slow_en", i, 8'(i == 0 ? slow_a : slow_b), 8'(m_mode[i] == M_RUN));
    chk("time_up", i, 8'(i == 0 ? tu_a : tu_b),     8'(m_tu[i]));
  endtask

  task automatic step(input bit t, input bit p, input bit sa, input bit sb, input bit r);
    bit rise;
    tick = t; pause = p; start_a = sa; start_b = sb; reset = r;
    @(posedge CLOCK_50);
    rise = t && !m_tq;
    model_edge(0, r, sa, p, rise);
    model_edge(1, r, sb, p, rise);
    m_tq = r ? t : 1'b1;
    #1;
    check_inst(0);
    check_inst(1);
    $display("t=%0t tick=%0b pause=%0b start=%0b%0b reset=%0b | A=%0d%0d B=%0d%0d tu=%0b%0b",
             $time, t, p, sa, sb, r, tens_a, ones_a, tens_b, ones_b, tu_a, tu_b);
  endtask

  // One tick low-for-one-cycle pulse; the rising edge lands on the second step.
  task automatic pulses(input bit p, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, p, 1'b0, 1'b0, 1'b1);
      step(1'b1, p, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    m_tq = 1'b1;
    // Reset for 3 cycles with tick already high.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Start both, then count: A 60->57, B 02->01->00 then stays expired.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    pulses(1'b0, 3);
    // Bring A to 45, then pause with a coincident tick rise.
    pulses(1'b0, 12);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pulses(1'b1, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pulses(1'b0, 1);
    // From 44 to 30, then start together with a tick rise.
    pulses(1'b0, 14);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // From 60 to 12, then reset while running.
    pulses(1'b0, 48);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(3) != 0, $urandom_range(7) == 0, $urandom_range(19) == 0,
           $urandom_range(19) == 0, $urandom_range(99) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_timer.md
# game_timer

Two-digit BCD countdown timer that consumes the 1-second tick produced by the slow-clock generator and drives the round clock shown on the DE-series seven-segment displays. It enables the slow-clock generator while a round is running, counts down from a configurable start value on each tick, supports pause, and raises a one-cycle `time_up` pulse for the game controller at 00.

## Interface

Parameters:
- `START_TENS`, default 6: tens digit loaded on reset and on `start`. Legal range 0–9.
- `START_ONES`, default 0: ones digit loaded on reset and on `start`. Legal range 0–9.

Ports:
- `CLOCK_50` in 1: system clock, 50 MHz. This is the only clock.
- `reset` in 1: synchronous, active-low reset, sampled on the rising edge of `CLOCK_50`.
- `tick` in 1: level from the slow-clock generator. It is high while enabled and drops low for one cycle at each 1 s wrap. A rising edge marks one second.
- `start` in 1: level, sampled each cycle. It loads the start value and starts the countdown.
- `pause` in 1: level. While high, the countdown is frozen.
- `slow_enable` out 1: drives the slow-clock generator's `enable`. Equal to `running`.
- `tens` out 4: BCD tens digit.
- `ones` out 4: BCD ones digit.
- `HEX1` out 7: active-low segments for `tens`, ordered gfedcba.
- `HEX0` out 7: active-low segments for `ones`, ordered gfedcba.
- `running` out 1: high in state RUN.
- `expired` out 1: high in state EXPIRED.
- `time_up` out 1: one-cycle pulse on entry to EXPIRED.

## Operation

- Edge detect: `tick_q` is registered each cycle. `tick_rise = tick & ~tick_q`. `tick_q` resets to 1, so a `tick` that is already high at reset is not counted.
- States and transitions:
  - IDLE:
    - Digits hold the start value.
    - `start` → RUN.
  - RUN:
    - `start` → reload the start value and stay in RUN (restart).
    - Otherwise `pause` → PAUSE. Any `tick_rise` in the same cycle is dropped.
    - Otherwise `tick_rise` → decrement.
  - PAUSE:
    - Ticks are ignored.
    - `start` → reload, then RUN.
    - `pause` low → RUN.
  - EXPIRED:
    - Digits hold 00.
    - `start` → reload, then RUN.
- Decrement rules:
  - `ones != 0`: `ones - 1`.
  - `ones == 0`: `ones := 9` and `tens - 1`.
  - If the result is 00, the next state is EXPIRED and `time_up` = 1 for exactly that cycle.
- Start value 00: `start` goes directly to EXPIRED with a `time_up` pulse. It never enters RUN.
- Priority: reset > `start` > `pause` > `tick_rise`.
- Digit registers never hold a non-BCD value. There is no wrap below 00.

## Timing

- Reset values:
  - state IDLE.
  - `tens` = START_TENS, `ones` = START_ONES.
  - `tick_q` = 1.
  - `time_up`, `running`, `expired`, `slow_enable` = 0.
  - `HEX1`/`HEX0` = encodings of the start digits.
- Tick latency: `tick` sampled high with `tick_q` low at edge N → new digits are visible after edge N. That is one clock of latency.
- `time_up` asserts in the same cycle the digits first read 00 and deasserts one cycle later.
- `start` sampled at edge N → state and digits are updated after edge N. `slow_enable` rises in the same cycle.
- `running`, `expired`, `slow_enable` decode directly from the state register (no extra register stage).
- HEX outputs are combinational from the digit registers: zero extra latency.
- Reset mid-count: the next edge forces every reset value, including lowering `slow_enable`, and drops any pending `time_up`.
- A held `start` level keeps reloading; counting begins on the first `tick_rise` after `start` falls.

## Structure

- Shared package (`game_pkg`):
  - state encoding (IDLE=0, RUN=1, PAUSE=2, EXPIRED=3).
  - BCD width constant (4).
  - seven-segment width constant (7).
- Sub-module `bcd_to_hex7`: combinational BCD → active-low 7-segment. It is instantiated twice and reusable by the score display. Inputs 10–15 → all segments off (7'h7F).
- Top file holds the edge detector, the FSM, and the digit counters.

## Test plan

- Reset with `reset`=0 for 3 cycles:
  - `tens`/`ones` = 6/0.
  - `HEX1` = 7'h02, `HEX0` = 7'h40.
  - `running` = 0, `slow_enable` = 0, `time_up` = 0.
- `start` for 1 cycle, then 3 `tick` low-for-one-cycle pulses:
  - digits go 60 → 59 → 58 → 57.
  - each change lands exactly 1 clock after the `tick` rising edge.
- Parameters START = 0/2, run 2 ticks:
  - digits 01 then 00.
  - `time_up` high for exactly 1 cycle.
  - `expired` = 1, `slow_enable` = 0.
  - further ticks leave 00.
- In RUN at 45, `pause` high with `tick_rise` in the same cycle, then 2 more ticks:
  - digits stay 45.
  - after `pause` drops, the next tick gives 44.
- `start` and `tick_rise` in the same cycle at 30:
  - digits reload to 60, with no decrement.
- Assert `reset` low while in RUN at 12:
  - after that edge, state IDLE, digits 60, `slow_enable` = 0, no `time_up` pulse.
